// File: rtl/score_input_controller.sv
// Pushbutton front end for the score counter: synchronize, debounce and edge-detect
// the +1/+10/clear buttons, arbitrate +1/+10 collisions and qualify clear by holding.
module score_input_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc1,
  input  logic btn_inc10,
  input  logic btn_reset,
  output logic inc1_pulse,
  output logic inc10_pulse,
  output logic reset_ready,
  output logic reset_arming
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, ARMING, FIRED} state_t;

  // channel order: [2] clear, [1] +10, [0] +1
  logic [2:0]    raw;
  logic [2:0]    sync_p0, sync_p1, deb_p2, deb_prev;
  logic [1:0]    ev_p3;
  logic [DW-1:0] db_cnt [3];

  state_t        state, next_state;
  logic [HW-1:0] hold_cnt, next_hold_cnt;
  logic          fire;
  logic          pend, next_pend;
  logic          next_inc1, next_inc10;

  assign raw = {btn_reset, btn_inc10, btn_inc1};

  // Stage p0/p1 synchronizer, p2 debounce, p3 registered rising-edge events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      deb_p2   <= '0;
      deb_prev <= '0;
      ev_p3    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      deb_prev <= deb_p2;
      ev_p3    <= deb_p2[1:0] & ~deb_prev[1:0];
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb_p2[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear qualification: one strobe per press, only after a full hold
  always_comb begin
    next_state    = state;
    next_hold_cnt = hold_cnt;
    fire          = 1'b0;
    case (state)
      IDLE: begin
        if (deb_p2[2]) begin
          next_state    = ARMING;
          next_hold_cnt = HW'(1);
        end
      end
      ARMING: begin
        if (!deb_p2[2]) begin
          next_state    = IDLE;
          next_hold_cnt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          next_state = FIRED;
          fire       = 1'b1;
        end else begin
          next_hold_cnt = hold_cnt + 1'b1;
        end
      end
      FIRED: begin
        if (!deb_p2[2]) begin
          next_state    = IDLE;
          next_hold_cnt = '0;
        end
      end
      default: begin
        next_state    = IDLE;
        next_hold_cnt = '0;
      end
    endcase
  end

  // +10 wins a collision; the losing +1 waits in a 1-deep pending flag
  always_comb begin
    next_inc1  = 1'b0;
    next_inc10 = 1'b0;
    next_pend  = pend;
    if (state != IDLE) begin
      next_pend = 1'b0;
    end else if (ev_p3[1]) begin
      next_inc10 = 1'b1;
      next_pend  = pend | ev_p3[0];
    end else if (pend || ev_p3[0]) begin
      next_inc1 = 1'b1;
      next_pend = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      pend        <= 1'b0;
      inc1_pulse  <= 1'b0;
      inc10_pulse <= 1'b0;
      reset_ready <= 1'b0;
    end else begin
      state       <= next_state;
      hold_cnt    <= next_hold_cnt;
      pend        <= next_pend;
      inc1_pulse  <= next_inc1;
      inc10_pulse <= next_inc10;
      reset_ready <= fire;
    end
  end

  assign reset_arming = (state == ARMING);

endmodule

// File: tb/tb_score_input_controller.sv
// Directed bench for score_input_controller: logs outputs edge by edge after a
// stimulus change and compares counts and first-high indices with hand-derived values.
module tb_score_input_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_inc1, btn_inc10, btn_reset;
  logic inc1_pulse, inc10_pulse, reset_ready, reset_arming;

  int n_tests = 0;
  int n_fail  = 0;

  int idx;
  int c1, c10, cr, ca, both;
  int f1, f10, fr, fa;
  int last_a;

  score_input_controller #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_inc1     (btn_inc1),
    .btn_inc10    (btn_inc10),
    .btn_reset    (btn_reset),
    .inc1_pulse   (inc1_pulse),
    .inc10_pulse  (inc10_pulse),
    .reset_ready  (reset_ready),
    .reset_arming (reset_arming)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_log();
    idx = 0; c1 = 0; c10 = 0; cr = 0; ca = 0; both = 0;
    f1 = -1; f10 = -1; fr = -1; fa = -1; last_a = 0;
  endtask

  // Index 0 is the first rising edge after the most recent input change.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (inc1_pulse)   begin c1++;  if (f1 < 0)  f1 = idx;  end
      if (inc10_pulse)  begin c10++; if (f10 < 0) f10 = idx; end
      if (reset_ready)  begin cr++;  if (fr < 0)  fr = idx;  end
      if (reset_arming) begin ca++;  if (fa < 0)  fa = idx;  end
      if (inc1_pulse && inc10_pulse) both++;
      last_a = int'(reset_arming);
      idx++;
    end
  endtask

  initial begin
    rst_n = 1'b0; btn_inc1 = 1'b1; btn_inc10 = 1'b1; btn_reset = 1'b1;
    start_log();
    capture(2);
    check("rst_inc1", int'(inc1_pulse), 0);
    check("rst_inc10", int'(inc10_pulse), 0);
    check("rst_ready", int'(reset_ready), 0);
    check("rst_arming", int'(reset_arming), 0);
    btn_inc1 = 1'b0; btn_inc10 = 1'b0; btn_reset = 1'b0;
    capture(1);
    rst_n = 1'b1;
    start_log();
    capture(30);
    check("post_rst_quiet", c1 + c10 + cr + ca, 0);

    // 3-cycle glitch must be filtered
    start_log();
    btn_inc1 = 1'b1;
    capture(3);
    btn_inc1 = 1'b0;
    capture(20);
    check("glitch_inc1", c1, 0);

    // clean press: one pulse, 7 edges after first sample, nothing on release
    start_log();
    btn_inc1 = 1'b1;
    capture(20);
    check("press_inc1_cnt", c1, 1);
    check("press_inc1_lat", f1, 7);
    start_log();
    btn_inc1 = 1'b0;
    capture(20);
    check("release_inc1", c1, 0);

    // collision: +10 first, +1 the next cycle
    start_log();
    btn_inc1 = 1'b1; btn_inc10 = 1'b1;
    capture(20);
    check("coll_inc10_lat", f10, 7);
    check("coll_inc1_lat", f1, 8);
    check("coll_counts", c1 * 10 + c10, 11);
    check("coll_both", both, 0);
    btn_inc1 = 1'b0; btn_inc10 = 1'b0;
    capture(20);

    // long clear hold
    start_log();
    btn_reset = 1'b1;
    capture(40);
    check("hold_arm_first", fa, 6);
    check("hold_arm_len", ca, 16);
    check("hold_ready_idx", fr, 22);
    check("hold_ready_cnt", cr, 1);
    btn_reset = 1'b0;
    capture(20);
    check("hold_ready_total", cr, 1);
    check("hold_arm_end", last_a, 0);

    // short clear hold: arming for 15 cycles, no strobe
    start_log();
    btn_reset = 1'b1;
    capture(15);
    btn_reset = 1'b0;
    capture(25);
    check("short_ready", cr, 0);
    check("short_arm_len", ca, 15);
    check("short_arm_end", last_a, 0);

    // lockout in ARMING and FIRED
    start_log();
    btn_reset = 1'b1;
    capture(10);
    btn_inc10 = 1'b1;
    capture(10);
    btn_inc10 = 1'b0;
    capture(10);
    btn_inc10 = 1'b1;
    capture(20);
    btn_inc10 = 1'b0;
    capture(10);
    btn_reset = 1'b0;
    capture(20);
    check("lock_inc10", c10, 0);
    check("lock_ready", cr, 1);
    start_log();
    btn_inc10 = 1'b1;
    capture(20);
    check("unlock_inc10_cnt", c10, 1);
    check("unlock_inc10_lat", f10, 7);
    btn_inc10 = 1'b0;
    capture(20);

    // reset during ARMING with +1 in flight
    start_log();
    btn_reset = 1'b1;
    capture(10);
    btn_inc1 = 1'b1;
    capture(4);
    rst_n = 1'b0; btn_inc1 = 1'b0; btn_reset = 1'b0;
    capture(1);
    check("mid_rst_arming", int'(reset_arming), 0);
    rst_n = 1'b1;
    start_log();
    capture(40);
    check("mid_rst_inc1", c1, 0);
    check("mid_rst_ready", cr, 0);
    check("mid_rst_arm", ca, 0);
    start_log();
    btn_inc1 = 1'b1;
    capture(20);
    check("redeb_inc1_lat", f1, 7);
    check("redeb_inc1_cnt", c1, 1);
    btn_inc1 = 1'b0;
    capture(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
